// File: rtl/wb_mux.sv
// Writeback-stage source select and write-enable qualification, plus a
// one-entry registered copy of the last committed write for decode bypass.
module wb_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [1:0]            wb_sel,
  input  logic                  reg_write_in,
  input  logic                  kill_wb,
  input  logic [4:0]            rd_in,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic                  reg_write_out,
  output logic [4:0]            rd_out,
  output logic                  fwd_valid,
  output logic [4:0]            fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  // No handshake: one writeback is presented and consumed every cycle.

  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_sel_ok;
  logic                  w_write;

  logic                  r_fwd_valid;
  logic [4:0]            r_fwd_rd;
  logic [DATA_WIDTH-1:0] r_fwd_data;

  // Only the three known encodings enable a write; reserved or unknown
  // selects fall into the default arm and suppress it.
  always_comb begin
    w_wdata  = '0;
    w_sel_ok = 1'b0;
    case (wb_sel)
      2'd0: begin
        w_wdata  = alu_result;
        w_sel_ok = 1'b1;
      end
      2'd1: begin
        w_wdata  = rdata;
        w_sel_ok = 1'b1;
      end
      2'd2: begin
        w_wdata  = pc_plus4;
        w_sel_ok = 1'b1;
      end
      default: begin
        w_wdata  = '0;
        w_sel_ok = 1'b0;
      end
    endcase
  end

  assign w_write = reg_write_in & ~kill_wb & (rd_in != 5'd0) & w_sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_valid <= 1'b0;
      r_fwd_rd    <= 5'd0;
      r_fwd_data  <= '0;
    end else if (w_write) begin
      r_fwd_valid <= 1'b1;
      r_fwd_rd    <= rd_in;
      r_fwd_data  <= w_wdata;
    end else begin
      r_fwd_valid <= 1'b0;
    end
  end

  assign rd_wdata      = w_wdata;
  assign reg_write_out = w_write;
  assign rd_out        = rd_in;
  assign fwd_valid     = r_fwd_valid;
  assign fwd_rd        = r_fwd_rd;
  assign fwd_data      = r_fwd_data;

endmodule

// File: tb/tb_wb_mux.sv
// Bench for wb_mux: directed and random writebacks checked against a
// behavioural model; forward-register expectations go through a queue.
module tb_wb_mux;
  localparam int DW = 32;
  localparam int FW = 1 + 5 + DW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] rdata;
  logic [DW-1:0] pc_plus4;
  logic [1:0]    wb_sel;
  logic          reg_write_in;
  logic          kill_wb;
  logic [4:0]    rd_in;
  logic [DW-1:0] rd_wdata;
  logic          reg_write_out;
  logic [4:0]    rd_out;
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [DW-1:0] fwd_data;

  wb_mux #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .rdata        (rdata),
    .pc_plus4     (pc_plus4),
    .wb_sel       (wb_sel),
    .reg_write_in (reg_write_in),
    .kill_wb      (kill_wb),
    .rd_in        (rd_in),
    .rd_wdata     (rd_wdata),
    .reg_write_out(reg_write_out),
    .rd_out       (rd_out),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  int n_checks = 0;
  int n_errors = 0;
  logic [FW-1:0] exp_q[$];

  // reference model of the forward register (what decode should see)
  logic          m_valid = 1'b0;
  logic [4:0]    m_rd    = 5'd0;
  logic [DW-1:0] m_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply one writeback between edges, check the combinational
  // outputs, then queue the forward-register state expected after the edge
  task automatic drive(input logic r, input logic [DW-1:0] a, input logic [DW-1:0] m,
                       input logic [DW-1:0] p, input logic [1:0] sel, input logic we,
                       input logic k, input logic [4:0] rd);
    logic [DW-1:0] e_data;
    logic          e_we;
    logic          sel_known;
    @(negedge clk);
    rst = r; alu_result = a; rdata = m; pc_plus4 = p;
    wb_sel = sel; reg_write_in = we; kill_wb = k; rd_in = rd;
    #1;
    sel_known = !$isunknown(sel);
    if (!sel_known)     e_data = '0;
    else if (sel == 0)  e_data = a;
    else if (sel == 1)  e_data = m;
    else if (sel == 2)  e_data = p;
    else                e_data = '0;
    e_we = sel_known && (sel != 2'd3) && we && !k && (rd != 5'd0);
    if (sel_known) chk("rd_wdata", 64'(rd_wdata), 64'(e_data));
    chk("reg_write_out", 64'(reg_write_out), 64'(e_we));
    chk("rd_out", 64'(rd_out), 64'(rd));
    if (r) begin
      m_valid = 1'b0; m_rd = 5'd0; m_data = '0;
    end else if (e_we) begin
      m_valid = 1'b1; m_rd = rd; m_data = e_data;
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_valid, m_rd, m_data});
  endtask

  // monitor: the forward register presents a new value after every edge
  initial begin
    logic [FW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_valid", 64'(fwd_valid), 64'(e[FW-1]));
        chk("fwd_rd", 64'(fwd_rd), 64'(e[FW-2 -: 5]));
        chk("fwd_data", 64'(fwd_data), 64'(e[DW-1:0]));
        if (e[FW-1] && fwd_rd == 5'd0) chk("fwd_rd_nonzero", 64'(fwd_rd), 64'd1);
      end
    end
  end

  localparam logic [DW-1:0] A = 32'hA1A1A1A1;
  localparam logic [DW-1:0] B = 32'hB2B2B2B2;
  localparam logic [DW-1:0] C = 32'hC3C3C3C3;

  initial begin
    logic [1:0] xsel;
    rst = 1'b1; alu_result = '0; rdata = '0; pc_plus4 = '0;
    wb_sel = 2'd0; reg_write_in = 1'b0; kill_wb = 1'b0; rd_in = 5'd0;

    drive(1, A, B, C, 2'd0, 1, 0, 5'd10);   // reset held over an edge
    drive(0, A, B, C, 2'd0, 1, 0, 5'd10);   // ALU path
    drive(0, A, B, C, 2'd1, 1, 0, 5'd10);
    drive(0, A, B, C, 2'd2, 1, 0, 5'd10);
    drive(0, A, B, C, 2'd3, 1, 0, 5'd10);   // reserved
    drive(0, A, B, C, 2'd2, 1, 1, 5'd10);   // kill
    drive(0, A, B, C, 2'd2, 1, 0, 5'd10);
    drive(0, A, B, C, 2'd0, 1, 0, 5'd0);    // x0
    drive(0, A, B, C, 2'd0, 1, 0, 5'd31);
    drive(0, A, B, C, 2'd0, 1, 1, 5'd0);    // kill and x0
    drive(0, 32'h12345678, B, C, 2'd0, 1, 0, 5'd5);
    drive(0, 32'h12345678, B, C, 2'd0, 1, 1, 5'd5);
    drive(0, 32'h12345678, B, C, 2'd0, 1, 1, 5'd7);
    drive(0, A, B, C, 2'd1, 1, 0, 5'd9);
    drive(1, A, B, C, 2'd1, 1, 0, 5'd9);    // reset mid-stream
    drive(0, A, B, C, 2'd1, 0, 0, 5'd9);    // no write after reset
    xsel = 2'bxx;
    drive(0, A, B, C, xsel, 1, 0, 5'd4);    // unknown select

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), $urandom, $urandom, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
    end

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
